// File: rtl/fsk_pkg.sv
// fsk_pkg: shared FSK constants and demodulator state type.
// Used by the demodulator and by the modulator for the sample midscale.
package fsk_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACQ1,
    ACQ2,
    LOCK
  } state_e;

  localparam int MID          = 128;
  localparam int SPACE_PERIOD = 32;
  localparam int MARK_PERIOD  = 21;
  localparam int THRESH       = 27;
  localparam int MIN_PERIOD   = 16;
  localparam int MAX_PERIOD   = 40;

endpackage

// File: rtl/fsk_zero_cross.sv
// fsk_zero_cross: hysteresis midscale comparator with rising-edge pulse.
// Ports: clk, reset (async low), sample_in, sample_valid -> rise.
module fsk_zero_cross #(
  parameter int SAMPLE_W = 8,
  parameter int MID      = 128,
  parameter int HYST     = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  output logic                rise
);

  localparam logic [SAMPLE_W-1:0] HI_TH = SAMPLE_W'(MID + HYST);
  localparam logic [SAMPLE_W-1:0] LO_TH = SAMPLE_W'(MID - HYST);

  logic hi_q;
  logic hi_d;
  logic above;
  logic below;

  assign above = (sample_in >= HI_TH);
  assign below = (sample_in < LO_TH);

  always_comb begin
    hi_d = hi_q;
    if (sample_valid) begin
      if (above) begin
        hi_d = 1'b1;
      end else if (below) begin
        hi_d = 1'b0;
      end
    end
  end

  // Combinational so the period counter captures on the edge sample.
  assign rise = sample_valid & ~hi_q & above;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q <= 1'b0;
    end else begin
      hi_q <= hi_d;
    end
  end

endmodule

// File: rtl/fsk_demodulator.sv
// fsk_demodulator: period-measuring FSK demodulator with lock FSM and vote filter.
// Ports: clk, reset (async low), sample_in/valid -> bit_out, bit_valid, carrier_ok, period_out.
module fsk_demodulator #(
  parameter int SAMPLE_W   = 8,
  parameter int MID        = fsk_pkg::MID,
  parameter int HYST       = 8,
  parameter int CNT_W      = 6,
  parameter int THRESH     = fsk_pkg::THRESH,
  parameter int MIN_PERIOD = fsk_pkg::MIN_PERIOD,
  parameter int MAX_PERIOD = fsk_pkg::MAX_PERIOD,
  parameter int VOTE       = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  output logic                bit_out,
  output logic                bit_valid,
  output logic                carrier_ok,
  output logic [CNT_W-1:0]    period_out
);

  import fsk_pkg::*;

  localparam int VOTE_W = (VOTE > 1) ? $clog2(VOTE) : 1;

  logic              rise;
  logic              legal;
  logic              cls;
  logic              timeout;

  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [CNT_W-1:0]  per_q;
  logic [CNT_W-1:0]  per_d;
  logic              bit_q;
  logic              bit_d;
  logic              bv_q;
  logic              bv_d;
  logic [VOTE_W-1:0] vote_q;
  logic [VOTE_W-1:0] vote_d;
  state_e            state_q;
  state_e            state_d;

  fsk_zero_cross #(
    .SAMPLE_W(SAMPLE_W),
    .MID     (MID),
    .HYST    (HYST)
  ) u_zc (
    .clk         (clk),
    .reset       (reset),
    .sample_in   (sample_in),
    .sample_valid(sample_valid),
    .rise        (rise)
  );

  // cnt_q is the period on the edge sample.
  assign legal = (cnt_q >= CNT_W'(MIN_PERIOD))
               & (cnt_q <= CNT_W'(MAX_PERIOD));
  assign cls   = (cnt_q < CNT_W'(THRESH));

  // Fires on the sample that would push the count past MAX_PERIOD.
  assign timeout = sample_valid & ~rise
                 & (cnt_q >= CNT_W'(MAX_PERIOD));

  always_comb begin
    cnt_d = cnt_q;
    per_d = per_q;
    if (sample_valid) begin
      if (rise) begin
        per_d = cnt_q;
        cnt_d = CNT_W'(1);
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Edge wins over a coincident timeout.
  always_comb begin
    state_d = state_q;
    if (rise) begin
      unique case (state_q)
        IDLE:    state_d = ACQ1;
        ACQ1:    state_d = legal ? ACQ2 : ACQ1;
        ACQ2:    state_d = legal ? LOCK : ACQ1;
        LOCK:    state_d = legal ? LOCK : IDLE;
        default: state_d = IDLE;
      endcase
    end else if (timeout) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    bit_d  = bit_q;
    vote_d = vote_q;
    bv_d   = 1'b0;
    if (rise && legal) begin
      if (state_q == ACQ2) begin
        bit_d  = cls;
        vote_d = '0;
      end else if (state_q == LOCK) begin
        bv_d = 1'b1;
        if (cls == bit_q) begin
          vote_d = '0;
        end else if (vote_q == VOTE_W'(VOTE - 1)) begin
          bit_d  = cls;
          vote_d = '0;
        end else begin
          vote_d = vote_q + VOTE_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      per_q  <= '0;
      bit_q  <= 1'b0;
      bv_q   <= 1'b0;
      vote_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      per_q  <= per_d;
      bit_q  <= bit_d;
      bv_q   <= bv_d;
      vote_q <= vote_d;
    end
  end

  assign bit_out    = bit_q;
  assign bit_valid  = bv_q;
  assign carrier_ok = (state_q == LOCK);
  assign period_out = per_q;

endmodule

// File: tb/tb_fsk_demodulator.sv
// tb_fsk_demodulator: randomized FSK stimulus checked against a behavioural model.
// Model works on sample indices and acquisition stage counts.
module tb_fsk_demodulator;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] sample_in;
  logic       sample_valid;
  logic       bit_out;
  logic       bit_valid;
  logic       carrier_ok;
  logic [5:0] period_out;

  int checks = 0;
  int errors = 0;
  int ph = 0;

  fsk_demodulator dut (
    .clk         (clk),
    .reset       (reset),
    .sample_in   (sample_in),
    .sample_valid(sample_valid),
    .bit_out     (bit_out),
    .bit_valid   (bit_valid),
    .carrier_ok  (carrier_ok),
    .period_out  (period_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: n counts valid samples, last_n is the index of
  // the last rising crossing, stage counts acquisition progress (3=locked),
  // run counts consecutive opposite decisions since lock or last flip.
  bit m_hi   = 1'b0;
  int n      = 0;
  int last_n = 0;
  int stage  = 0;
  int run    = 0;
  int m_bit  = 0;
  int e_bv   = 0;
  int e_per  = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_hi = 1'b0; n = 0; last_n = 0; stage = 0;
      run = 0; m_bit = 0; e_bv = 0; e_per = 0;
    end else begin
      e_bv = 0;
      if (sample_valid) begin
        int s;
        bit up;
        s  = int'(sample_in);
        up = !m_hi && s >= 136;
        if (s >= 136) m_hi = 1'b1;
        else if (s < 120) m_hi = 1'b0;
        if (up) begin
          int p;
          bit ok;
          int c;
          p = n - last_n;
          if (p > 63) p = 63;
          last_n = n;
          e_per = p;
          ok = (p >= 16) && (p <= 40);
          c = (p < 27) ? 1 : 0;
          if (stage == 0) stage = 1;
          else if (stage == 1) begin
            if (ok) stage = 2;
          end else if (stage == 2) begin
            if (ok) begin
              stage = 3; m_bit = c; run = 0;
            end else stage = 1;
          end else begin
            if (!ok) stage = 0;
            else begin
              e_bv = 1;
              if (c == m_bit) run = 0;
              else begin
                run++;
                if (run == 2) begin
                  m_bit = c; run = 0;
                end
              end
            end
          end
        end else if (n - last_n + 1 > 40) begin
          stage = 0;
        end
        n++;
      end
    end
  end

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      chk("bit_out", int'(bit_out), m_bit);
      chk("bit_valid", int'(bit_valid), e_bv);
      chk("carrier_ok", int'(carrier_ok), (stage == 3) ? 1 : 0);
      chk("period_out", int'(period_out), e_per);
    end
  end

  task automatic drive(input int s, input bit v);
    @(posedge clk);
    #1;
    sample_in = 8'(s);
    sample_valid = v;
  endtask

  // One valid sample, preceded by random idle cycles when vpct < 100.
  task automatic put(input int s, input int vpct);
    while (int'($urandom_range(99, 0)) >= vpct)
      drive(int'($urandom_range(255, 0)), 1'b0);
    drive(s, 1'b1);
  endtask

  // step 2 = space (32 samples/cycle), step 3 = mark (64/3 samples/cycle)
  task automatic sine(input int nv, input int step, input int vpct);
    for (int i = 0; i < nv; i++) begin
      real r;
      r = 100.0 * $sin(6.283185307 * real'(ph) / 64.0);
      put(128 + $rtoi(r), vpct);
      ph = (ph + step) % 64;
    end
  endtask

  task automatic square(input int p, input int vpct);
    for (int k = 0; k < p; k++)
      put((k < p / 2) ? 200 : 50, vpct);
  endtask

  initial begin
    reset = 1'b0;
    sample_in = 8'd128;
    sample_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_bit", int'(bit_out), 0);
    chk("rst_bv", int'(bit_valid), 0);
    chk("rst_ok", int'(carrier_ok), 0);
    chk("rst_per", int'(period_out), 0);
    @(posedge clk);
    #2 reset = 1'b1;

    sine(256, 2, 100);
    chk("space_per", int'(period_out), 32);
    chk("space_bit", int'(bit_out), 0);
    chk("space_lock", int'(carrier_ok), 1);

    sine(200, 3, 100);
    chk("mark_per", (period_out == 21 || period_out == 22) ? 1 : 0, 1);
    chk("mark_bit", int'(bit_out), 1);

    sine(128, 2, 100);
    chk("space_ret", int'(bit_out), 0);

    repeat (4) square(32, 100);
    square(21, 100);
    repeat (3) square(32, 100);
    chk("one_mark_bit", int'(bit_out), 0);
    chk("one_mark_ok", int'(carrier_ok), 1);
    square(21, 100);
    square(21, 100);
    square(32, 100);
    chk("two_mark_bit", int'(bit_out), 1);

    for (int i = 0; i < 50; i++) put(128, 100);
    chk("loss_ok", int'(carrier_ok), 0);

    repeat (10) square(10, 100);
    chk("sq10_ok", int'(carrier_ok), 0);
    chk("sq10_per", int'(period_out), 10);

    for (int i = 0; i < 60; i++) put(123 + int'($urandom_range(10, 0)), 100);
    chk("noise_per", int'(period_out), 10);

    sine(300, 2, 50);
    chk("half_per", int'(period_out), 32);
    chk("half_ok", int'(carrier_ok), 1);

    repeat (10) begin
      int sel;
      sel = int'($urandom_range(2, 0));
      if (sel == 0)
        sine(int'($urandom_range(150, 20)), 2, int'($urandom_range(100, 40)));
      else if (sel == 1)
        sine(int'($urandom_range(150, 20)), 3, int'($urandom_range(100, 40)));
      else
        repeat (int'($urandom_range(6, 1)))
          square(int'($urandom_range(45, 10)), int'($urandom_range(100, 60)));
    end

    sine(160, 2, 100);
    chk("pre_rst_ok", int'(carrier_ok), 1);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("mid_rst_bit", int'(bit_out), 0);
    chk("mid_rst_bv", int'(bit_valid), 0);
    chk("mid_rst_ok", int'(carrier_ok), 0);
    chk("mid_rst_per", int'(period_out), 0);
    @(posedge clk);
    #2 reset = 1'b1;
    sine(128, 2, 100);
    chk("relock_ok", int'(carrier_ok), 1);

    @(posedge clk);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fsk_demodulator.md
Name: fsk_demodulator

Overview:
Downstream consumer of the 1000 Hz / 1500 Hz FSK sine-sample stream (8-bit unsigned, midscale 128, 32 samples per space cycle, 1.5 mark cycles per 32 samples).
- Detects midscale crossings with hysteresis and measures the period between rising crossings in samples.
- Classifies each period as mark (1) or space (0), filters the decisions and emits recovered bits with a valid strobe.
- Sits after the DAC-side sample path in loopback and bench test, and before the bit sink.

Parameters:
- SAMPLE_W, 8, sample width
- MID, 128, midscale (zero) level
- HYST, 8, hysteresis half-band; high threshold MID+HYST, low threshold MID-HYST
- CNT_W, 6, period counter width; saturates at 2^CNT_W-1
- THRESH, 27, period below THRESH means mark (1); THRESH or above means space (0)
- MIN_PERIOD, 16, shortest legal period
- MAX_PERIOD, 40, longest legal period; also the carrier-loss timeout
- VOTE, 2, consecutive equal classifications required to change bit_out

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- sample_in  in  SAMPLE_W  unsigned sample
- sample_valid  in  1  sample qualifier; tie high when the modulator updates every clk
- bit_out  out  1  filtered recovered bit
- bit_valid  out  1  one-cycle pulse per accepted period while locked
- carrier_ok  out  1  high in LOCK only
- period_out  out  CNT_W  last measured period, registered

Behaviour:
- Reset (async, reset==0): comparator state LO, period counter 0, FSM IDLE, vote counter 0, bit_out 0, bit_valid 0, carrier_ok 0, period_out 0.
- Only cycles with sample_valid=1 advance any state. bit_valid is forced low on every other cycle.
- Comparator:
  - LO to HI when sample_in >= MID+HYST.
  - HI to LO when sample_in < MID-HYST.
  - Otherwise holds.
  - A rising edge is a LO to HI transition on a valid sample.
- Period counter:
  - On a valid sample with a rising edge, the counter is captured and then loads 1.
  - Otherwise it increments, saturating at all-ones.
  - Captured period P equals the number of valid samples between successive rising edges.
- Classification: on a rising edge with MIN_PERIOD <= P <= MAX_PERIOD, class = (P < THRESH). Any other P is illegal.
- FSM, evaluated on rising edges and on timeout. Timeout means the counter exceeds MAX_PERIOD with no edge, checked every valid sample.
  - IDLE: first rising edge goes to ACQ1. Its P is discarded because it is a partial period.
  - ACQ1: legal P goes to ACQ2. Illegal P stays in ACQ1. Timeout goes to IDLE.
  - ACQ2: legal P goes to LOCK, and bit_out is preset to that class with vote=0. Illegal P goes to ACQ1. Timeout goes to IDLE.
  - LOCK: legal P updates the filter and pulses bit_valid. Illegal P or timeout goes to IDLE, with carrier_ok 0 and no bit_valid.
- Vote filter, in LOCK:
  - If class == bit_out, vote clears to 0.
  - Otherwise vote increments. When it reaches VOTE-1, bit_out takes the class and vote clears.
  - Net effect: bit_out changes after VOTE consecutive opposite classifications.
- Latency: period_out, bit_out and bit_valid register one clk after the edge sample. carrier_ok rises in the same registered cycle as the ACQ2-to-LOCK transition.
- Expected periods from the modulator: space 32; mark alternating 21/22. Both are clear of THRESH.
- Simultaneous timeout and edge: the edge wins.
- An asynchronous reset mid-period returns everything to the reset values immediately.

Decomposition:
- Package fsk_pkg:
  - state enum {IDLE, ACQ1, ACQ2, LOCK}
  - MID, SPACE_PERIOD=32, MARK_PERIOD=21, and the default THRESH, MIN_PERIOD and MAX_PERIOD values
  - shared with the modulator for the sample midscale
- Sub-module fsk_zero_cross: hysteresis comparator plus rising-edge pulse (clk, reset, sample_in, sample_valid, rise).
- The period counter, FSM and vote filter stay in the top module.

Test Plan:
- Modulator looped back, dado=0 held for 256 samples -> carrier_ok rises after the 3rd rising edge; period_out=32; bit_out=0; bit_valid pulses every 32 samples.
- Modulator dado=1 held -> period_out alternates 21/22; bit_out becomes 1 after 2 mark periods; bit_valid pulses about every 21.3 samples.
- Locked on space, inject a single 21-sample mark period -> bit_out stays 0 (vote=1, no flip). Two consecutive mark periods -> bit_out=1.
- sample_in held at 128 for 50 samples while locked -> at counter 41, carrier_ok=0, FSM IDLE, no bit_valid.
- Square wave with a 10-sample period -> FSM never leaves ACQ1; carrier_ok stays 0. Noise of ±5 around 128 -> no rising edges.
- sample_valid toggling 50% while the modulator advances only on valid -> same periods as the valid-only count; assert reset mid-lock -> all outputs 0 within the same cycle.
